stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 The block SHALL have parameter data_width, default 8, the data word width.
REQ-002 The block SHALL have parameter STACK_depth, default 8, the entry count of the shared stack; CW = clog2(STACK_depth+1).
REQ-003 The block SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_a / req_b  in  1  per-requester request, level.
REQ-006 op_a / op_b  in  2  operation: 00 push, 01 pop, 10 peak, 11 illegal.
REQ-007 din_a / din_b  in  data_width  push data.
REQ-008 gnt_a / gnt_b  out  1  one-cycle grant pulse.
REQ-009 done_a / done_b  out  1  one-cycle completion pulse.
REQ-010 err_a / err_b  out  1  qualifies done: operation rejected.
REQ-011 dout_a / dout_b  out  data_width  pop/peak result, valid with done.
REQ-012 stk_push, stk_pop, stk_peak  out  1  stack command strobes, one-hot or all zero.
REQ-013 stk_dataIn  out  data_width  stack write data.
REQ-014 stk_dataOut  in  data_width  stack read data, updated on the rising edge ending the command cycle.
REQ-015 count  out  CW  current occupancy; full / empty  out  1  count==STACK_depth / count==0.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP; one operation in flight at a time.
REQ-017 IDLE: at a rising edge with any req high, select a winner, latch its op and din, go to ISSUE; no req -> stay IDLE.
REQ-018 Arbitration SHALL be round-robin: with both requesting, the requester not granted last wins; single requester always wins; after reset A has priority.
REQ-019 gnt_x SHALL be high exactly during the ISSUE cycle of requester x's operation.
REQ-020 Requesters SHALL hold op/din stable while req is high until gnt; req still high on return to IDLE counts as a new request.
REQ-021 ISSUE, legal op: drive exactly one stk_* strobe for this one cycle; stk_dataIn = latched din on push, else 0.
REQ-022 Illegal ops (push when full; pop or peak when empty; op 11): no strobe; go to RESP with err.
REQ-023 ISSUE -> RESP for push or illegal ops; ISSUE -> CAPTURE for legal pop/peak.
REQ-024 CAPTURE: sample stk_dataOut into dout of the winner at the edge ending CAPTURE; go to RESP.
REQ-025 RESP: done_x high one cycle; err_x high in that cycle only if rejected; go to IDLE.
REQ-026 Latency from grant edge to done: push 2 cycles (ISSUE, RESP), pop/peak 3 (ISSUE, CAPTURE, RESP).
REQ-027 count SHALL increment at the edge ending a legal push ISSUE, decrement for a legal pop, be unchanged for peak or rejects; it never leaves 0..STACK_depth.
REQ-028 dout_x SHALL hold its value until the next successful pop/peak for x; push and rejects leave it unchanged.
REQ-029 Outputs of the non-winning requester SHALL stay 0 (gnt, done, err) throughout the operation.
REQ-030 All stk_*, gnt, done and err outputs SHALL be registered or decoded from state only, never combinational from req.

Reset
REQ-031 rst high SHALL immediately force state IDLE, count 0, all strobes, gnt, done and err to 0, dout_a/dout_b to 0, priority to A.
REQ-032 rst mid-operation SHALL abort it with no done; the system SHALL reset the stack concurrently, since count is not resynchronised.

Verification
REQ-033 Depth 4: A pushes 0x11,0x22 -> gnt_a then done_a 2 cycles later each, count 2, stk_push one cycle each.
REQ-034 A pops from count 2 -> done_a 3 cycles after grant, dout_a=0x22, count 1; peak -> dout_a=0x11, count stays 1.
REQ-035 req_a and req_b high continuously, both push -> grants alternate A,B,A,B; after 4 pushes count 4, full=1.
REQ-036 Push when full and pop when empty, plus op 11 -> done with err=1, no stk_* strobe, count unchanged.
REQ-037 rst asserted during CAPTURE of a pop -> outputs 0 immediately, no done, count 0, next request granted to A.

Source files
------------

// File: rtl/stack_arbiter_if.sv
// Bundle of the two requester ports and the shared-stack command bus served by stack_arbiter.
// The arbiter takes the slave view; the requesters and the stack take the master view.
interface stack_arbiter_if #(
  parameter int data_width  = 8,
  parameter int STACK_depth = 8
);
  localparam int CW = $clog2(STACK_depth + 1);

  logic                  req_a, req_b;
  logic [1:0]            op_a, op_b;
  logic [data_width-1:0] din_a, din_b;
  logic                  gnt_a, gnt_b;
  logic                  done_a, done_b;
  logic                  err_a, err_b;
  logic [data_width-1:0] dout_a, dout_b;
  logic                  stk_push, stk_pop, stk_peak;
  logic [data_width-1:0] stk_dataIn;
  logic [data_width-1:0] stk_dataOut;
  logic [CW-1:0]         count;
  logic                  full, empty;

  modport slave (
    input  req_a, req_b, op_a, op_b, din_a, din_b, stk_dataOut,
    output gnt_a, gnt_b, done_a, done_b, err_a, err_b, dout_a, dout_b,
    output stk_push, stk_pop, stk_peak, stk_dataIn, count, full, empty
  );

  modport master (
    output req_a, req_b, op_a, op_b, din_a, din_b, stk_dataOut,
    input  gnt_a, gnt_b, done_a, done_b, err_a, err_b, dout_a, dout_b,
    input  stk_push, stk_pop, stk_peak, stk_dataIn, count, full, empty
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack between two requesters, one operation in flight.
// Grants, strobes and completions are decoded from registered state only.
module stack_arbiter #(
  parameter int data_width  = 8,
  parameter int STACK_depth = 8
) (
  input  logic           clk,
  input  logic           rst,
  stack_arbiter_if.slave bus
);
  localparam int CW = $clog2(STACK_depth + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(STACK_depth);
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEAK = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                state, state_nxt;
  logic                  win_b, prio_b, err_r;
  logic [1:0]            op_r;
  logic [data_width-1:0] din_r;
  logic [CW-1:0]         count_r;
  logic [data_width-1:0] dout_a_r, dout_b_r;
  logic                  any_req, sel_b, is_full, is_empty, legal;
  logic                  push_s, pop_s, peak_s;

  always_comb begin
    any_req   = bus.req_a || bus.req_b;
    // prio_b set means A was granted last, so B wins a tie
    sel_b     = bus.req_b && (!bus.req_a || prio_b);
    is_full   = (count_r == FULL_CNT);
    is_empty  = (count_r == '0);
    legal     = ((op_r == OP_PUSH) && !is_full) ||
                (((op_r == OP_POP) || (op_r == OP_PEAK)) && !is_empty);
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = (legal && (op_r != OP_PUSH)) ? CAPTURE : RESP;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prio_b   <= 1'b0;
      win_b    <= 1'b0;
      err_r    <= 1'b0;
      count_r  <= '0;
      dout_a_r <= '0;
      dout_b_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        win_b  <= sel_b;
        prio_b <= !sel_b;
      end
      if (state == ISSUE) begin
        err_r <= !legal;
        if (push_s)     count_r <= count_r + CW'(1);
        else if (pop_s) count_r <= count_r - CW'(1);
      end
      // stack read data settled at the edge ending ISSUE
      if (state == CAPTURE) begin
        if (win_b) dout_b_r <= bus.stk_dataOut;
        else       dout_a_r <= bus.stk_dataOut;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      op_r  <= sel_b ? bus.op_b  : bus.op_a;
      din_r <= sel_b ? bus.din_b : bus.din_a;
    end
  end

  assign push_s = (state == ISSUE) && legal && (op_r == OP_PUSH);
  assign pop_s  = (state == ISSUE) && legal && (op_r == OP_POP);
  assign peak_s = (state == ISSUE) && legal && (op_r == OP_PEAK);

  assign bus.stk_push   = push_s;
  assign bus.stk_pop    = pop_s;
  assign bus.stk_peak   = peak_s;
  assign bus.stk_dataIn = push_s ? din_r : '0;

  assign bus.gnt_a  = (state == ISSUE) && !win_b;
  assign bus.gnt_b  = (state == ISSUE) &&  win_b;
  assign bus.done_a = (state == RESP)  && !win_b;
  assign bus.done_b = (state == RESP)  &&  win_b;
  assign bus.err_a  = (state == RESP)  && !win_b && err_r;
  assign bus.err_b  = (state == RESP)  &&  win_b && err_r;
  assign bus.dout_a = dout_a_r;
  assign bus.dout_b = dout_b_r;
  assign bus.count  = count_r;
  assign bus.full   = is_full;
  assign bus.empty  = is_empty;
endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized bench for stack_arbiter: a queue-based model of the shared stack and
// round-robin rule predicts winner, latency, error, result data and occupancy.
module tb_stack_arbiter;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_arbiter_if #(.data_width(DW), .STACK_depth(DEPTH)) bus ();
  stack_arbiter #(.data_width(DW), .STACK_depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural stack attached to the arbiter's command bus
  logic [DW-1:0] smem [0:DEPTH-1];
  int            sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp              <= 0;
      bus.stk_dataOut <= '0;
    end else if (bus.stk_push && sp < DEPTH) begin
      smem[sp] <= bus.stk_dataIn;
      sp       <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      bus.stk_dataOut <= smem[sp-1];
      sp              <= sp - 1;
    end else if (bus.stk_peak && sp > 0) begin
      bus.stk_dataOut <= smem[sp-1];
    end
  end

  // Reference model
  logic [DW-1:0] ref_q[$];
  bit            ref_prio_b;
  logic [DW-1:0] ref_dout_a, ref_dout_b;

  task automatic model_reset();
    ref_q.delete();
    ref_prio_b = 1'b0;
    ref_dout_a = '0;
    ref_dout_b = '0;
  endtask

  task automatic drive_idle();
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.op_a  = 2'b00; bus.op_b = 2'b00;
    bus.din_a = '0;    bus.din_b = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, bus.count, ref_q.size());
    check({tag, "_full"},  bus.full,  ref_q.size() == DEPTH);
    check({tag, "_empty"}, bus.empty, ref_q.size() == 0);
    check({tag, "_dout_a"}, bus.dout_a, ref_dout_a);
    check({tag, "_dout_b"}, bus.dout_b, ref_dout_b);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_outs"},
          {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.err_a, bus.err_b,
           bus.stk_push, bus.stk_pop, bus.stk_peak}, 9'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check_state("reset");
    rst = 1'b0;
  endtask

  // One arbitrated operation, requests dropped once a grant is seen
  task automatic transact(input bit ra, input bit rb, input logic [1:0] oa, input logic [1:0] ob,
                          input logic [DW-1:0] da, input logic [DW-1:0] db);
    bit            wb, legal, rd, done_seen, err_seen;
    logic [1:0]    op;
    logic [DW-1:0] d, pushed_val, val;
    int            lat, pushes, pops, peaks, other_act;
    @(negedge clk);
    bus.req_a = ra; bus.op_a = oa; bus.din_a = da;
    bus.req_b = rb; bus.op_b = ob; bus.din_b = db;
    wb    = rb && (!ra || ref_prio_b);
    op    = wb ? ob : oa;
    d     = wb ? db : da;
    legal = (op == 2'b00 && ref_q.size() < DEPTH) ||
            ((op == 2'b01 || op == 2'b10) && ref_q.size() > 0);
    rd    = legal && (op != 2'b00);
    @(negedge clk);
    check("gnt_a", bus.gnt_a, !wb);
    check("gnt_b", bus.gnt_b, wb);
    drive_idle();
    pushes = 0; pops = 0; peaks = 0; other_act = 0;
    pushed_val = '0; done_seen = 0; err_seen = 0; lat = 0;
    pushes += bus.stk_push; pops += bus.stk_pop; peaks += bus.stk_peak;
    if (bus.stk_push) pushed_val = bus.stk_dataIn;
    other_act += wb ? (bus.done_a | bus.err_a) : (bus.done_b | bus.err_b);
    for (int c = 1; c <= 4 && !done_seen; c++) begin
      @(negedge clk);
      pushes += bus.stk_push; pops += bus.stk_pop; peaks += bus.stk_peak;
      if (bus.stk_push) pushed_val = bus.stk_dataIn;
      other_act += wb ? (bus.gnt_a | bus.done_a | bus.err_a) : (bus.gnt_b | bus.done_b | bus.err_b);
      if (wb ? bus.done_b : bus.done_a) begin
        done_seen = 1;
        lat       = c;
        err_seen  = wb ? bus.err_b : bus.err_a;
      end
    end
    check("done_seen", done_seen, 1);
    check("latency", lat, rd ? 2 : 1);
    check("err", err_seen, !legal);
    check("stk_push_cnt", pushes, legal && op == 2'b00);
    check("stk_pop_cnt",  pops,   legal && op == 2'b01);
    check("stk_peak_cnt", peaks,  legal && op == 2'b10);
    if (legal && op == 2'b00) check("stk_dataIn", pushed_val, d);
    check("loser_quiet", other_act, 0);
    if (legal) begin
      val = '0;
      case (op)
        2'b00:   ref_q.push_back(d);
        2'b01:   val = ref_q.pop_back();
        default: val = ref_q[$];
      endcase
      if (rd) begin
        if (wb) ref_dout_b = val;
        else    ref_dout_a = val;
      end
    end
    ref_prio_b = !wb;
    check_state("op");
  endtask

  function automatic logic [1:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)      return 2'b00;
    else if (r < 7) return 2'b01;
    else if (r < 9) return 2'b10;
    else            return 2'b11;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            ngnt, sel;
    bit            exp_b, seen_done;
    logic [DW-1:0] rda, rdb;
    drive_idle();
    model_reset();
    apply_reset();

    // Basic push/pop/peak from A
    transact(1, 0, 2'b00, 2'b00, 8'h11, 8'h00);
    transact(1, 0, 2'b00, 2'b00, 8'h22, 8'h00);
    transact(1, 0, 2'b01, 2'b00, 8'h00, 8'h00);
    check("pop_val", bus.dout_a, 8'h22);
    transact(1, 0, 2'b10, 2'b00, 8'h00, 8'h00);
    check("peak_val", bus.dout_a, 8'h11);

    // Both requesting continuously: strict alternation until full
    apply_reset();
    @(negedge clk);
    bus.req_a = 1'b1; bus.op_a = 2'b00; bus.din_a = 8'hA1;
    bus.req_b = 1'b1; bus.op_b = 2'b00; bus.din_b = 8'hB1;
    ngnt = 0;
    for (int c = 0; c < 40 && ngnt < 4; c++) begin
      @(negedge clk);
      if (bus.gnt_a || bus.gnt_b) begin
        exp_b = ref_prio_b;
        check("rr_grant_b", bus.gnt_b, exp_b);
        ref_q.push_back(bus.gnt_b ? 8'hB1 : 8'hA1);
        ref_prio_b = !bus.gnt_b;
        ngnt++;
        if (ngnt == 4) drive_idle();
      end
    end
    check("rr_grants", ngnt, 4);
    repeat (2) @(negedge clk);
    check_state("rr");
    check("rr_full", bus.full, 1);

    // Rejections: push when full, op 11, then drain and read while empty
    transact(0, 1, 2'b00, 2'b00, 8'h00, 8'h55);
    transact(1, 0, 2'b11, 2'b00, 8'h66, 8'h00);
    for (int i = 0; i < DEPTH; i++) transact(0, 1, 2'b00, 2'b01, 8'h00, 8'h00);
    transact(1, 0, 2'b01, 2'b00, 8'h00, 8'h00);
    transact(0, 1, 2'b00, 2'b10, 8'h00, 8'h00);

    // Reset during CAPTURE of a pop
    transact(1, 0, 2'b00, 2'b00, 8'h33, 8'h00);
    @(negedge clk);
    bus.req_a = 1'b1; bus.op_a = 2'b01;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_quiet("rst_capture");
    check_state("rst_capture");
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      seen_done |= bus.done_a | bus.done_b;
    end
    check("rst_no_done", seen_done, 0);
    transact(1, 1, 2'b00, 2'b00, 8'h44, 8'h77);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(1, 3);
      rda = 8'($urandom);
      rdb = 8'($urandom);
      transact(sel[0], sel[1], rand_op(), rand_op(), rda, rdb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
